// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, datapath mux
// selects, FSM states and the decoded-instruction / control-word structs.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_OR     = 3'b010,
        ALU_PASS_B = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RS     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_PC     = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP
    } inst_class_e;

    typedef struct packed {
        inst_class_e cls;
        logic        illegal;
        logic        is_sub;
        logic        is_lui;
        logic        is_lw;
        logic        is_jr;
        logic        is_jal;
    } dec_t;

    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     iord;
        logic     pc_we;
        logic     ir_we;
        logic     mdr_we;
        logic     reg_we;
        reg_dst_e reg_dst;
        wb_sel_e  wb_sel;
        logic     alu_src_a;
        src_b_e   alu_src_b;
        alu_op_e  alu_op;
        ext_op_e  ext_op;
        pc_src_e  pc_src;
    } ctrl_t;

    // States in which the controller holds a memory request open.
    function automatic logic is_req_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// per-instruction qualifiers and an illegal-instruction flag.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec     = '0;
        dec.cls = CLS_ALU_R;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: dec.cls = CLS_ALU_R;
                    FN_SUBU: begin
                        dec.cls    = CLS_ALU_R;
                        dec.is_sub = 1'b1;
                    end
                    FN_JR: begin
                        dec.cls   = CLS_JUMP;
                        dec.is_jr = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ORI:  dec.cls = CLS_ALU_I;
            OP_LUI: begin
                dec.cls    = CLS_ALU_I;
                dec.is_lui = 1'b1;
            end
            OP_LW: begin
                dec.cls   = CLS_MEM;
                dec.is_lw = 1'b1;
            end
            OP_SW:   dec.cls = CLS_MEM;
            OP_BEQ:  dec.cls = CLS_BRANCH;
            OP_J:    dec.cls = CLS_JUMP;
            OP_JAL: begin
                dec.cls    = CLS_JUMP;
                dec.is_jal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/writeback,
// traps on illegal opcodes and memory timeouts, and counts retired instructions.
module mc_control
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic [1:0]       pc_src,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] retired
);

    // Counter only needs to reach TIMEOUT-1; the trap fires on that cycle.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e            state;
    state_e            state_nxt;
    dec_t              dec;
    ctrl_t             ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              retire;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    mc_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    assign timeout_hit = (TIMEOUT != 0) && is_req_state(state) && !mem_ready &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) ||
                    (state == S_BRANCH) || (state == S_JUMP) ||
                    ((state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec.illegal) begin
                    state_nxt = S_TRAP;
                end else begin
                    case (dec.cls)
                        CLS_ALU_R:  state_nxt = S_EXEC_R;
                        CLS_ALU_I:  state_nxt = S_EXEC_I;
                        CLS_MEM:    state_nxt = S_MEM_ADDR;
                        CLS_BRANCH: state_nxt = S_BRANCH;
                        CLS_JUMP:   state_nxt = S_JUMP;
                        default:    state_nxt = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R:   state_nxt = S_WB_ALU;
            S_EXEC_I:   state_nxt = S_WB_ALU;
            S_MEM_ADDR: state_nxt = dec.is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nxt = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_WB_ALU:   state_nxt = S_FETCH;
            S_WB_MEM:   state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_TRAP;
        endcase
        if (timeout_hit) state_nxt = S_TRAP;
    end

    // Request states are only left on ready, so clearing on ready (or outside
    // a request state) guarantees a fresh count on every new access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!is_req_state(state) || mem_ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_cause <= 1'b0;
        end else if ((state != S_TRAP) && (state_nxt == S_TRAP)) begin
            trap_cause <= timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign trap = (state == S_TRAP);

    // FETCH enables are gated by reset so no request leaves while it is held.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = reset;
                ctrl.ir_we     = reset & mem_ready;
                ctrl.pc_we     = reset & mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.ext_op    = EXT_SIGN;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = dec.is_sub ? ALU_SUB : ALU_ADD;
            end
            S_EXEC_I: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = dec.is_lui ? ALU_PASS_B : ALU_OR;
                ctrl.ext_op    = dec.is_lui ? EXT_UPPER : EXT_ZERO;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = EXT_SIGN;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.mdr_we  = mem_ready;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_WB_ALU: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = (dec.cls == CLS_ALU_R) ? DST_RD : DST_RT;
            end
            S_WB_MEM: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = WB_MDR;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_we     = zero;
                ctrl.pc_src    = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = dec.is_jr ? PC_RS : PC_JUMP;
                if (dec.is_jal) begin
                    ctrl.reg_we  = 1'b1;
                    ctrl.reg_dst = DST_RA;
                    ctrl.wb_sel  = WB_PC;
                end
            end
            default: ctrl = '0;
        endcase
    end

    assign mem_req   = ctrl.mem_req;
    assign mem_we    = ctrl.mem_we;
    assign iord      = ctrl.iord;
    assign pc_we     = ctrl.pc_we;
    assign ir_we     = ctrl.ir_we;
    assign mdr_we    = ctrl.mdr_we;
    assign reg_we    = ctrl.reg_we;
    assign reg_dst   = ctrl.reg_dst;
    assign wb_sel    = ctrl.wb_sel;
    assign alu_src_a = ctrl.alu_src_a;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign ext_op    = ctrl.ext_op;
    assign pc_src    = ctrl.pc_src;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction step model with random
// instructions and memory waits, plus directed trap/timeout/reset scenarios.
module tb_mc_control;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instr = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, pc_we, ir_we, mdr_we, reg_we;
    logic [1:0]    reg_dst, wb_sel, alu_src_b, ext_op, pc_src;
    logic          alu_src_a;
    logic [2:0]    alu_op;
    logic          trap, trap_cause;
    logic [CW-1:0] retired;

    mc_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mdr_we     (mdr_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .pc_src     (pc_src),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, pc_we, ir_we, mdr_we, reg_we;
        logic [1:0] reg_dst, wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op, pc_src;
    } cv_t;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_e;
    typedef enum int {P_FETCH, P_DEC, P_EXR, P_EXI, P_MA, P_MRD, P_MWR, P_WB, P_WBM, P_BR, P_JMP, P_TRAP} ph_e;

    typedef struct {
        cv_t           cv;
        logic          trap;
        logic          cause;
        logic [CW-1:0] ret;
        int            ph;
    } exp_t;

    cv_t           act;
    cv_t           snap;
    exp_t          exp_q[$];
    logic [CW-1:0] ret_model = '0;
    int            checks = 0;
    int            passes = 0;
    int            mdr_pulses = 0;

    assign act = {mem_req, mem_we, iord, pc_we, ir_we, mdr_we, reg_we, reg_dst, wb_sel,
                  alu_src_a, alu_src_b, alu_op, ext_op, pc_src};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // What the outputs must be in a given step of an instruction.
    function automatic cv_t exp_cv(kind_e k, ph_e p, bit rdy, bit z);
        cv_t c;
        c = '0;
        case (p)
            P_FETCH: begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_we = rdy; c.pc_we = rdy; end
            P_DEC:   begin c.alu_src_b = 2'b11; c.ext_op = 2'b01; end
            P_EXR:   begin c.alu_src_a = 1; c.alu_op = (k == K_SUBU) ? 3'b001 : 3'b000; end
            P_EXI:   begin
                c.alu_src_b = 2'b10;
                c.alu_op    = (k == K_LUI) ? 3'b011 : 3'b010;
                c.ext_op    = (k == K_LUI) ? 2'b10 : 2'b00;
            end
            P_MA:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 2'b01; end
            P_MRD:   begin c.mem_req = 1; c.iord = 1; c.mdr_we = rdy; end
            P_MWR:   begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
            P_WB:    begin c.reg_we = 1; c.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00; end
            P_WBM:   begin c.reg_we = 1; c.wb_sel = 2'b01; end
            P_BR:    begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_we = z; c.pc_src = 2'b01; end
            P_JMP:   begin
                c.pc_we  = 1;
                c.pc_src = (k == K_JR) ? 2'b11 : 2'b10;
                if (k == K_JAL) begin c.reg_we = 1; c.reg_dst = 2'b10; c.wb_sel = 2'b10; end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] gen_instr(kind_e k);
        logic [31:0] r;
        logic [5:0]  f;
        r = $urandom;
        case (k)
            K_ADDU: return {6'h00, r[25:6], 6'h21};
            K_SUBU: return {6'h00, r[25:6], 6'h23};
            K_JR:   return {6'h00, r[25:6], 6'h08};
            K_ORI:  return {6'h0D, r[25:0]};
            K_LUI:  return {6'h0F, r[25:0]};
            K_LW:   return {6'h23, r[25:0]};
            K_SW:   return {6'h2B, r[25:0]};
            K_BEQ:  return {6'h04, r[25:0]};
            K_J:    return {6'h02, r[25:0]};
            K_JAL:  return {6'h03, r[25:0]};
            default: begin
                f = 6'($urandom_range(0, 63));
                if (r[31]) begin
                    while (f inside {6'h21, 6'h23, 6'h08}) f = 6'($urandom_range(0, 63));
                    return {6'h00, r[25:6], f};
                end
                while (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B})
                    f = 6'($urandom_range(0, 63));
                return {f, r[25:0]};
            end
        endcase
    endfunction

    // One clock cycle: drive inputs, queue the expectation, snapshot outputs.
    task automatic drv(ph_e p, kind_e k, bit rdy, bit z, bit etrap, bit ecause);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e.cv      = exp_cv(k, p, rdy, z);
        e.trap    = etrap;
        e.cause   = ecause;
        e.ret     = ret_model;
        e.ph      = int'(p);
        exp_q.push_back(e);
        @(negedge clk);
        snap = act;
        if (snap.mdr_we) mdr_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(kind_e k, logic [31:0] iv, int fw, int mw, bit bz);
        instr = iv;
        repeat (fw) drv(P_FETCH, k, 0, rb(), 0, 0);
        drv(P_FETCH, k, 1, rb(), 0, 0);
        drv(P_DEC, k, rb(), rb(), 0, 0);
        case (k)
            K_ADDU, K_SUBU: begin drv(P_EXR, k, rb(), rb(), 0, 0); drv(P_WB, k, rb(), rb(), 0, 0); end
            K_ORI, K_LUI:   begin drv(P_EXI, k, rb(), rb(), 0, 0); drv(P_WB, k, rb(), rb(), 0, 0); end
            K_LW: begin
                drv(P_MA, k, rb(), rb(), 0, 0);
                repeat (mw) drv(P_MRD, k, 0, rb(), 0, 0);
                drv(P_MRD, k, 1, rb(), 0, 0);
                drv(P_WBM, k, rb(), rb(), 0, 0);
            end
            K_SW: begin
                drv(P_MA, k, rb(), rb(), 0, 0);
                repeat (mw) drv(P_MWR, k, 0, rb(), 0, 0);
                drv(P_MWR, k, 1, rb(), 0, 0);
            end
            K_BEQ:           drv(P_BR, k, rb(), bz, 0, 0);
            K_J, K_JAL, K_JR: drv(P_JMP, k, rb(), rb(), 0, 0);
            default:         repeat (20) drv(P_TRAP, k, rb(), rb(), 1, 0);
        endcase
        if (k != K_ILL) ret_model = ret_model + CW'(1);
    endtask

    // Hold reset for one edge and release #1 after the next, so the first
    // request cycle starts exactly when the driver resumes.
    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_mem_req",   32'(mem_req),    32'd0);
        chk("rst_ir_we",     32'(ir_we),      32'd0);
        chk("rst_pc_we",     32'(pc_we),      32'd0);
        chk("rst_alu_src_b", 32'(alu_src_b),  32'd1);
        chk("rst_trap",      32'(trap),       32'd0);
        chk("rst_cause",     32'(trap_cause), 32'd0);
        chk("rst_retired",   32'(retired),    32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        ret_model = '0;
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("ctrl_ph%0d", e.ph), 32'(act), 32'(e.cv));
            chk($sformatf("trap_ph%0d", e.ph), 32'(trap), 32'(e.trap));
            if (e.trap) chk("trap_cause", 32'(trap_cause), 32'(e.cause));
            chk($sformatf("retired_ph%0d", e.ph), 32'(retired), 32'(e.ret));
        end
    end

    initial begin
        kind_e k;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(K_ADDU, gen_instr(K_ADDU), 0, 0, 0);
        run_instr(K_ORI, {6'h0D, 5'd1, 5'd2, 16'h00FF}, 0, 0, 0);
        chk("addu_ori_retired", 32'(retired), 32'd2);

        mdr_pulses = 0;
        run_instr(K_LW, gen_instr(K_LW), 0, 3, 0);
        chk("lw_mdr_pulses", 32'(mdr_pulses), 32'd1);
        chk("lw_retired", 32'(retired), 32'd3);

        run_instr(K_BEQ, gen_instr(K_BEQ), 0, 0, 1);
        chk("beq_taken_pc_we",  32'(snap.pc_we),  32'd1);
        chk("beq_taken_pc_src", 32'(snap.pc_src), 32'd1);
        run_instr(K_BEQ, gen_instr(K_BEQ), 0, 0, 0);
        chk("beq_not_taken_pc_we", 32'(snap.pc_we), 32'd0);

        run_instr(K_JAL, gen_instr(K_JAL), 0, 0, 0);
        chk("jal_pc_we",   32'(snap.pc_we),   32'd1);
        chk("jal_pc_src",  32'(snap.pc_src),  32'd2);
        chk("jal_reg_we",  32'(snap.reg_we),  32'd1);
        chk("jal_reg_dst", 32'(snap.reg_dst), 32'd2);
        chk("jal_wb_sel",  32'(snap.wb_sel),  32'd2);

        run_instr(K_ILL, {6'h3F, 26'h0}, 0, 0, 0);
        chk("ill_trap",    32'(trap),       32'd1);
        chk("ill_cause",   32'(trap_cause), 32'd0);
        chk("ill_enables", 32'(snap),       32'd0);
        chk("ill_retired", 32'(retired),    32'd6);
        do_reset();

        instr = gen_instr(K_ADDU);
        repeat (4) drv(P_FETCH, K_ADDU, 0, rb(), 0, 0);
        repeat (3) drv(P_TRAP, K_ADDU, rb(), rb(), 1, 1);
        chk("fetch_timeout_trap",  32'(trap),       32'd1);
        chk("fetch_timeout_cause", 32'(trap_cause), 32'd1);
        do_reset();

        run_instr(K_ADDU, gen_instr(K_ADDU), 3, 0, 0);
        chk("ready_4th_no_trap", 32'(trap),    32'd0);
        chk("ready_4th_retired", 32'(retired), 32'd1);

        instr = gen_instr(K_LW);
        drv(P_FETCH, K_LW, 1, 0, 0, 0);
        drv(P_DEC, K_LW, 0, 0, 0, 0);
        drv(P_MA, K_LW, 0, 0, 0, 0);
        repeat (4) drv(P_MRD, K_LW, 0, rb(), 0, 0);
        repeat (2) drv(P_TRAP, K_LW, rb(), rb(), 1, 1);
        chk("mrd_timeout_cause",   32'(trap_cause), 32'd1);
        chk("mrd_timeout_retired", 32'(retired),    32'd1);
        do_reset();

        run_instr(K_ADDU, gen_instr(K_ADDU), 0, 0, 0);
        instr = gen_instr(K_SW);
        drv(P_FETCH, K_SW, 1, 0, 0, 0);
        drv(P_DEC, K_SW, 0, 0, 0, 0);
        drv(P_MA, K_SW, 0, 0, 0, 0);
        mem_ready = 1'b0;
        #2;
        chk("mwr_mem_we_before_rst", 32'(mem_we),  32'd1);
        chk("mwr_retired_before_rst", 32'(retired), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_mem_req",   32'(mem_req),   32'd0);
        chk("async_rst_mem_we",    32'(mem_we),    32'd0);
        chk("async_rst_iord",      32'(iord),      32'd0);
        chk("async_rst_alu_src_b", 32'(alu_src_b), 32'd1);
        chk("async_rst_retired",   32'(retired),   32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        ret_model = '0;
        run_instr(K_ADDU, gen_instr(K_ADDU), 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            k = kind_e'($urandom_range(0, 10));
            run_instr(k, gen_instr(k), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            if (k == K_ILL) do_reset();
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle controller for the next-generation MIPS core, replacing the single-cycle controller under the `mips` top. Sequences each instruction through fetch/decode/execute/memory/writeback states, drives all datapath enables and muxes, and talks to a variable-latency memory through a req/ready handshake. Adds memory-timeout and illegal-opcode trapping plus a retired-instruction counter.

## Interface
- `TIMEOUT`, 255, max consecutive cycles `mem_req` may wait for `mem_ready`; 0 disables timeout
- `CNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `instr`  in  32  current IR contents (opcode [31:26], funct [5:0])
- `zero`  in  1  ALU zero flag, valid in BRANCH state
- `mem_ready`  in  1  memory completes the pending access this cycle
- `mem_req`, `mem_we`, `iord`  out  1 each  access request, write strobe, address select (0 = PC, 1 = ALUOut)
- `pc_we`, `ir_we`, `mdr_we`, `reg_we`  out  1 each  register write enables
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31
- `wb_sel`  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- `alu_src_a`  out  1  0 PC, 1 GPR[rs]
- `alu_src_b`  out  2  00 GPR[rt], 01 constant 4, 10 ext imm, 11 ext imm<<2
- `alu_op`  out  3  000 ADD, 001 SUB, 010 OR, 011 PASS_B
- `ext_op`  out  2  00 zero, 01 sign, 10 upper (imm<<16)
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump {PC[31:28],instr[25:0],2'b00}, 11 GPR[rs]
- `trap`  out  1  sticky: illegal opcode or memory timeout
- `trap_cause`  out  1  0 illegal, 1 timeout; valid when `trap`
- `retired`  out  CNT_W  instructions completed

## Operation
- Supported: addu, subu, jr (R-type), ori, lui, lw, sw, beq, j, jal. Anything else, including unknown funct, is illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD. On mem_ready: ir_we=1, pc_we=1 (pc_src 00), -> DECODE; else stay.
- DECODE: ALUOut <= PC + (sext imm<<2) (alu_src_b 11, ext_op 01). Dispatch: addu/subu -> EXEC_R; ori/lui -> EXEC_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j/jal/jr -> JUMP; illegal -> TRAP (cause 0).
- EXEC_R: src_a=1, src_b=00, ADD/SUB -> WB_ALU (reg_dst 01). EXEC_I: src_b=10, ori: OR, ext 00; lui: PASS_B, ext 10 -> WB_ALU (reg_dst 00).
- WB_ALU: reg_we=1, wb_sel 00 -> FETCH. MEM_ADDR: src_a=1, src_b=10, ext 01, ADD -> MEM_RD (lw) / MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1; on ready mdr_we=1 -> WB_MEM. WB_MEM: reg_we=1, wb_sel 01, reg_dst 00 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on ready -> FETCH.
- BRANCH: SUB of rs,rt; pc_we=zero, pc_src 01 -> FETCH. JUMP: pc_we=1; j/jal pc_src 10, jr 11; jal also reg_we=1, reg_dst 10, wb_sel 10 (PC already +4) -> FETCH.
- TRAP: all enables and mem_req 0; absorbing until reset.
- All outputs not listed for a state are 0 / 00 (enables never float high).

## Timing
- Moore outputs from state, except pc_we in BRANCH (depends on zero) and ready-qualified enables in FETCH/MEM_RD.
- Zero-wait memory cycle counts: R/I-type 4, lw 5, sw 4, beq/j/jal/jr 3. Each ready-low cycle adds one.
- Handshake: mem_req, mem_we, iord held stable until the cycle mem_ready is sampled high; mem_ready while mem_req=0 ignored.
- Timeout: wait counter clears on entering a request state; if mem_req has been high TIMEOUT cycles with no ready -> TRAP (cause 1) next edge. Ready on the TIMEOUT-th cycle wins (no trap).
- retired increments on the edge leaving WB_ALU, WB_MEM, MEM_WR(with ready), BRANCH, JUMP; wraps modulo 2^CNT_W. Not incremented for trapping instruction.
- Reset (any time, incl. mid-access): state FETCH, retired 0, trap 0, trap_cause 0, wait counter 0; outputs take FETCH values immediately (mem_req=1 after release only).

## Structure
- Shared package `mips_pkg`: opcode/funct constants, alu_op, ext_op, pc_src, reg_dst, wb_sel encodings, state enum.
- Single sub-module natural: `mc_decode` (combinational opcode/funct -> instruction class + illegal flag); FSM, timeout counter and retired counter in `mc_control`.

## Test plan
- Zero-wait addu then ori 0x00FF: state sequence FETCH,DECODE,EXEC_R,WB_ALU then FETCH,DECODE,EXEC_I,WB_ALU; retired=2 after 8 cycles.
- lw with mem_ready low 3 cycles in MEM_RD: lw takes 8 cycles, mdr_we pulses once, mem_req/iord stable throughout.
- beq with zero=1 then zero=0: pc_we=1 with pc_src 01 first, pc_we=0 second; each 3 cycles.
- jal: JUMP asserts pc_we, pc_src 10, reg_we, reg_dst 10, wb_sel 10 in same cycle.
- opcode 0x3F: TRAP after DECODE, trap=1, cause 0, all enables 0 for 20 cycles, retired unchanged; reset clears.
- TIMEOUT=4, mem_ready held low in FETCH: trap cause 1 after 4 request cycles; repeat with ready on 4th cycle -> no trap; async reset mid-MEM_WR returns to FETCH, retired=0.
